oam_dma_arbiter: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/cpu_bus_mux.sv | 43 ++++
 rtl/oam_dma_arbiter.sv | 143 ++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the cpu bus and the OAM DMA sequencer.
package cpu_bus_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned TRANSFER_LEN = 256;

    localparam logic [ADDR_W-1:0] DEFAULT_DMA_TRIGGER_ADDR = 16'h4014;
    localparam logic [ADDR_W-1:0] DEFAULT_OAM_DATA_ADDR    = 16'h2004;

    // Index of the final byte; the 8-bit index wraps to zero after it.
    localparam logic [DATA_W-1:0] LAST_INDEX = DATA_W'(TRANSFER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StRead,
        StWrite
    } dma_state_t;

endpackage

// File: rtl/cpu_bus_mux.sv
// Selects who drives the system bus: the cpu (pass-through) or the DMA sequencer.
module cpu_bus_mux
    import cpu_bus_pkg::*;
(
    input  logic              dma_active_i,
    input  logic [ADDR_W-1:0] cpu_address_i,
    input  logic              cpu_address_valid_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_data_valid_i,
    input  logic [ADDR_W-1:0] dma_address_i,
    input  logic              dma_address_valid_i,
    input  logic [DATA_W-1:0] dma_data_i,
    input  logic              dma_data_valid_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_data_valid_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_data_valid_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_address_valid_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_data_valid_o
);

    always_comb begin
        if (dma_active_i) begin
            // The cpu sees no read-valid while the DMA owns the bus, which stalls it.
            mem_address_o       = dma_address_i;
            mem_address_valid_o = dma_address_valid_i;
            mem_data_o          = dma_data_i;
            mem_data_valid_o    = dma_data_valid_i;
            cpu_data_o          = '0;
            cpu_data_valid_o    = 1'b0;
        end else begin
            mem_address_o       = cpu_address_i;
            mem_address_valid_o = cpu_address_valid_i;
            mem_data_o          = cpu_data_i;
            mem_data_valid_o    = cpu_data_valid_i;
            cpu_data_o          = mem_data_i;
            cpu_data_valid_o    = mem_data_valid_i;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Bus arbiter with a 256-byte page-to-OAM DMA engine started by a cpu write.
// Optional odd-cycle alignment tick: define DMA_ODD_CYCLE_ALIGN_EN.
module oam_dma_arbiter
    import cpu_bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DMA_TRIGGER_ADDR = DEFAULT_DMA_TRIGGER_ADDR,
    parameter logic [ADDR_W-1:0] OAM_DATA_ADDR    = DEFAULT_OAM_DATA_ADDR
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              tick_i,
    input  logic [ADDR_W-1:0] cpu_address_i,
    input  logic              cpu_address_valid_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_data_valid_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_data_valid_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_address_valid_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_data_valid_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_data_valid_i,
    output logic              dma_active_o
);

    dma_state_t        state_q, state_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic [DATA_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] latch_q, latch_d;

    logic              trigger;
    logic [ADDR_W-1:0] dma_address;
    logic              dma_address_valid;
    logic [DATA_W-1:0] dma_data;
    logic              dma_data_valid;

    assign trigger = cpu_address_valid_i & cpu_data_valid_i &
                     (cpu_address_i == DMA_TRIGGER_ADDR);
    assign dma_active_o = (state_q != StIdle);

`ifdef DMA_ODD_CYCLE_ALIGN_EN
    logic parity_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            parity_q <= 1'b0;
        end else if (tick_i) begin
            parity_q <= ~parity_q;
        end
    end
`endif

    always_comb begin
        state_d           = state_q;
        page_d            = page_q;
        index_d           = index_q;
        latch_d           = latch_q;
        dma_address       = '0;
        dma_address_valid = 1'b0;
        dma_data          = '0;
        dma_data_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                if (tick_i && trigger) begin
                    page_d  = cpu_data_i;
                    index_d = '0;
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (tick_i) begin
`ifdef DMA_ODD_CYCLE_ALIGN_EN
                    state_d = parity_q ? StAlign : StRead;
`else
                    state_d = StRead;
`endif
                end
            end
            StAlign: begin
                if (tick_i) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                dma_address       = {page_q, index_q};
                dma_address_valid = 1'b1;
                if (tick_i && mem_data_valid_i) begin
                    latch_d = mem_data_i;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                dma_address       = OAM_DATA_ADDR;
                dma_address_valid = 1'b1;
                dma_data          = latch_q;
                dma_data_valid    = 1'b1;
                if (tick_i) begin
                    // Index wraps inside the page; it never carries into page_q.
                    index_d = index_q + 8'd1;
                    state_d = (index_q == LAST_INDEX) ? StIdle : StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            page_q  <= '0;
            index_q <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            latch_q <= latch_d;
        end
    end

    cpu_bus_mux u_cpu_bus_mux (
        .dma_active_i        (dma_active_o),
        .cpu_address_i       (cpu_address_i),
        .cpu_address_valid_i (cpu_address_valid_i),
        .cpu_data_i          (cpu_data_i),
        .cpu_data_valid_i    (cpu_data_valid_i),
        .dma_address_i       (dma_address),
        .dma_address_valid_i (dma_address_valid),
        .dma_data_i          (dma_data),
        .dma_data_valid_i    (dma_data_valid),
        .mem_data_i          (mem_data_i),
        .mem_data_valid_i    (mem_data_valid_i),
        .cpu_data_o          (cpu_data_o),
        .cpu_data_valid_o    (cpu_data_valid_o),
        .mem_address_o       (mem_address_o),
        .mem_address_valid_o (mem_address_valid_o),
        .mem_data_o          (mem_data_o),
        .mem_data_valid_o    (mem_data_valid_o)
    );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: pass-through, DMA copies, wait states, reset abort.
module tb_oam_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b1;
    logic [15:0] cpu_address = '0;
    logic        cpu_address_valid = 1'b0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_data_valid = 1'b0;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_valid_out;
    logic [15:0] mem_address;
    logic        mem_address_valid;
    logic [7:0]  mem_data_out;
    logic        mem_data_valid_out;
    logic [7:0]  mem_data_in = '0;
    logic        mem_data_valid_in = 1'b0;
    logic        dma_active;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned tick_cnt;

    oam_dma_arbiter dut (
        .clock_i             (clk),
        .reset_ni            (rst_n),
        .tick_i              (tick),
        .cpu_address_i       (cpu_address),
        .cpu_address_valid_i (cpu_address_valid),
        .cpu_data_i          (cpu_data),
        .cpu_data_valid_i    (cpu_data_valid),
        .cpu_data_o          (cpu_data_out),
        .cpu_data_valid_o    (cpu_data_valid_out),
        .mem_address_o       (mem_address),
        .mem_address_valid_o (mem_address_valid),
        .mem_data_o          (mem_data_out),
        .mem_data_valid_o    (mem_data_valid_out),
        .mem_data_i          (mem_data_in),
        .mem_data_valid_i    (mem_data_valid_in),
        .dma_active_o        (dma_active)
    );

    always #5 clk = ~clk;

    // Ticks since reset; its LSB tracks the design's parity register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= 0;
        else if (tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_quiet();
        cpu_address       = 16'h0000;
        cpu_address_valid = 1'b0;
        cpu_data          = 8'h00;
        cpu_data_valid    = 1'b0;
    endtask

    task automatic test_reset();
        cpu_address = 16'h1111; cpu_address_valid = 1'b1;
        mem_data_in = 8'h22; mem_data_valid_in = 1'b1;
        #2;
        n_cmp++;
        if (dma_active !== 1'b0 || mem_address !== 16'h1111 || cpu_data_out !== 8'h22 ||
            cpu_data_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_passthru: active=%b addr=%h rd=%h rv=%b want 0 1111 22 1",
                     dma_active, mem_address, cpu_data_out, cpu_data_valid_out);
        end
        // A trigger write while reset is held must not start a DMA.
        cpu_address = 16'h4014; cpu_data = 8'h02; cpu_data_valid = 1'b1;
        step();
        n_cmp++;
        if (dma_active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_trigger_ignored: active=%b want 0", dma_active);
        end
        cpu_quiet();
        mem_data_valid_in = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_pass_through();
        cpu_address = 16'h8000; cpu_address_valid = 1'b1;
        mem_data_in = 8'h5A; mem_data_valid_in = 1'b1;
        #1;
        n_cmp++;
        if (mem_address !== 16'h8000 || mem_address_valid !== 1'b1 || cpu_data_out !== 8'h5A ||
            cpu_data_valid_out !== 1'b1 || dma_active !== 1'b0 || mem_data_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL passthru_read: addr=%h av=%b rd=%h rv=%b act=%b wv=%b want 8000 1 5A 1 0 0",
                     mem_address, mem_address_valid, cpu_data_out, cpu_data_valid_out,
                     dma_active, mem_data_valid_out);
        end
        // Write to a non-trigger address and a read of the trigger address: neither starts a DMA.
        cpu_address = 16'h4015; cpu_data = 8'h33; cpu_data_valid = 1'b1;
        mem_data_valid_in = 1'b0;
        #1;
        n_cmp++;
        if (mem_data_out !== 8'h33 || mem_data_valid_out !== 1'b1 || mem_address !== 16'h4015) begin
            n_err++;
            $display("FAIL passthru_write: data=%h wv=%b addr=%h want 33 1 4015",
                     mem_data_out, mem_data_valid_out, mem_address);
        end
        step();
        cpu_address = 16'h4014; cpu_data_valid = 1'b0;
        step();
        n_cmp++;
        if (dma_active !== 1'b0) begin
            n_err++;
            $display("FAIL near_miss_no_dma: active=%b want 0", dma_active);
        end
        cpu_quiet();
        step();
    endtask

    // Starts a DMA from the current (posedge+1) point and follows it with a zero/fixed-wait memory.
    task automatic run_dma(input logic [7:0] page, input int waits, input int stop_writes,
                           input string name);
        int active = 0, reads = 0, writes = 0, idle = 0;
        int bad_rd = 0, bad_wr = 0, stall = 0, wcnt = 0, extra = 0, exp_active;
        logic [7:0] rd_idx = 8'h00;
        logic [7:0] wr_idx = 8'h00;
        bit done = 1'b0, aborted = 1'b0;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
        extra = (tick_cnt[0] == 1'b0) ? 1 : 0;
`endif
        exp_active = 1 + extra + 256 * (waits + 2);
        cpu_address = 16'h4014; cpu_address_valid = 1'b1;
        cpu_data = page; cpu_data_valid = 1'b1;
        mem_data_valid_in = 1'b0;
        #1;
        n_cmp++;
        if (mem_address !== 16'h4014 || mem_data_valid_out !== 1'b1 || mem_data_out !== page) begin
            n_err++;
            $display("FAIL %s trigger_forwarded: addr=%h wv=%b data=%h want 4014 1 %h",
                     name, mem_address, mem_data_valid_out, mem_data_out, page);
        end
        step();
        // Keep hammering the trigger with another page; the DMA must ignore it.
        cpu_data = 8'h77;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) step();
            if (!dma_active) begin
                done = 1'b1;
                break;
            end
            active++;
            mem_data_valid_in = 1'b0;
            mem_data_in = 8'h00;
            if (cpu_data_valid_out !== 1'b0 || cpu_data_out !== 8'h00) stall++;
            if (mem_address_valid && !mem_data_valid_out) begin
                if (mem_address !== {page, rd_idx}) bad_rd++;
                if (wcnt < waits) begin
                    wcnt++;
                end else begin
                    mem_data_in = mem_address[7:0] ^ 8'hFF;
                    mem_data_valid_in = 1'b1;
                    wcnt = 0;
                    rd_idx++;
                    reads++;
                end
            end else if (mem_address_valid && mem_data_valid_out) begin
                if (mem_address !== 16'h2004 || mem_data_out !== (wr_idx ^ 8'hFF)) bad_wr++;
                wr_idx++;
                writes++;
                if (stop_writes != 0 && writes == stop_writes) begin
                    aborted = 1'b1;
                    break;
                end
            end else if (mem_data_valid_out) begin
                bad_wr++;
            end else begin
                idle++;
            end
        end
        if (!aborted) begin
            n_cmp++;
            if (!done) begin
                n_err++;
                $display("FAIL %s timeout: DMA still active after 3000 cycles", name);
            end
            n_cmp++;
            if (reads != 256 || writes != 256) begin
                n_err++;
                $display("FAIL %s counts: reads=%0d writes=%0d want 256 256", name, reads, writes);
            end
            n_cmp++;
            if (active != exp_active) begin
                n_err++;
                $display("FAIL %s active_ticks: got %0d want %0d", name, active, exp_active);
            end
            n_cmp++;
            if (idle != 1 + extra) begin
                n_err++;
                $display("FAIL %s idle_ticks: got %0d want %0d", name, idle, 1 + extra);
            end
            n_cmp++;
            if (bad_rd != 0 || bad_wr != 0) begin
                n_err++;
                $display("FAIL %s bus_errors: bad_reads=%0d bad_writes=%0d want 0 0",
                         name, bad_rd, bad_wr);
            end
            n_cmp++;
            if (stall != 0) begin
                n_err++;
                $display("FAIL %s cpu_stall: %0d cycles with cpu read-valid want 0", name, stall);
            end
            cpu_address = 16'h1234; cpu_address_valid = 1'b1; cpu_data_valid = 1'b0;
            mem_data_in = 8'hC3; mem_data_valid_in = 1'b1;
            #1;
            n_cmp++;
            if (mem_address !== 16'h1234 || cpu_data_out !== 8'hC3 || cpu_data_valid_out !== 1'b1) begin
                n_err++;
                $display("FAIL %s passthru_after: addr=%h rd=%h rv=%b want 1234 C3 1",
                         name, mem_address, cpu_data_out, cpu_data_valid_out);
            end
            cpu_quiet();
            mem_data_valid_in = 1'b0;
            step();
        end
    endtask

    task automatic test_basic_dma();
        run_dma(8'h02, 0, 0, "basic");
    endtask

    task automatic test_wait_states();
        run_dma(8'h02, 3, 0, "wait3");
    endtask

    task automatic test_page_wrap();
        run_dma(8'hFF, 0, 0, "page_ff");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            if (tick_cnt[0] != k[0]) step();
            run_dma(8'h10 + 8'(k), 0, 0, "b2b");
        end
    endtask

    task automatic test_tick_gating();
        int bad = 0;
        bit seen = 1'b0;
        cpu_address = 16'h4014; cpu_address_valid = 1'b1;
        cpu_data = 8'h07; cpu_data_valid = 1'b1;
        step();
        cpu_quiet();
        tick = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dma_active !== 1'b1 || mem_address_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL tick_hold: %0d cycles left HALT without a tick want 0", bad);
        end
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_address_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || mem_address !== 16'h0700) begin
            n_err++;
            $display("FAIL tick_resume: seen=%b addr=%h want 1 0700", seen, mem_address);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_dma();
        run_dma(8'h05, 0, 100, "abort");
        rst_n = 1'b0;
        cpu_address = 16'hABCD; cpu_address_valid = 1'b1; cpu_data_valid = 1'b0;
        mem_data_in = 8'h11; mem_data_valid_in = 1'b1;
        #1;
        n_cmp++;
        if (dma_active !== 1'b0 || mem_address !== 16'hABCD || mem_data_valid_out !== 1'b0 ||
            cpu_data_out !== 8'h11 || cpu_data_valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_dma: act=%b addr=%h wv=%b rd=%h rv=%b want 0 ABCD 0 11 1",
                     dma_active, mem_address, mem_data_valid_out, cpu_data_out, cpu_data_valid_out);
        end
        cpu_quiet();
        mem_data_valid_in = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_dma(8'h06, 0, 0, "restart");
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_basic_dma();
        test_wait_states();
        test_page_wrap();
        test_back_to_back();
        test_tick_gating();
        test_reset_mid_dma();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
